// File: rtl/host_rd_pkg.sv
// Shared types and constants for the host-memory read engine.
package host_rd_pkg;

  localparam int LINE_W    = 512;
  localparam int CL_ADDR_W = 42;
  localparam int CNT_W     = 17;

  typedef logic [CL_ADDR_W-1:0] t_cl_addr;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } t_rd_state;

  // Requested length limited to what the local line buffer can hold.
  function automatic logic [CNT_W-1:0] clamp_lines(input logic [15:0] num,
                                                   input logic [CNT_W-1:0] cap);
    logic [CNT_W-1:0] wide;
    wide = {1'b0, num};
    return (wide > cap) ? cap : wide;
  endfunction

endpackage

// File: rtl/rd_tag_tracker.sv
// Tracks issued, received and in-flight read counts for one transfer and
// decides whether another request may be launched.
module rd_tag_tracker
  import host_rd_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             issue_i,
  input  logic             rsp_i,
  input  logic [CNT_W-1:0] num_i,
  output logic             can_issue_o,
  output logic             all_received_o,
  output logic [CNT_W-1:0] issued_o
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0] issued_q;
  logic [CNT_W-1:0] received_q;
  logic [OW-1:0]    outst_q;
  logic             rsp_dec;

  assign rsp_dec = rsp_i && (outst_q != '0);

  // A same-cycle issue and response cancel out on the in-flight count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q   <= '0;
      received_q <= '0;
      outst_q    <= '0;
    end else if (clear_i) begin
      issued_q   <= '0;
      received_q <= '0;
      outst_q    <= '0;
    end else begin
      if (issue_i) issued_q <= issued_q + CNT_W'(1);
      if (rsp_i) received_q <= received_q + CNT_W'(1);
      case ({issue_i, rsp_dec})
        2'b10:   outst_q <= outst_q + OW'(1);
        2'b01:   outst_q <= outst_q - OW'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

  assign can_issue_o    = (outst_q < OW'(MAX_OUTSTANDING)) && (issued_q < num_i);
  assign all_received_o = (received_q == num_i);
  assign issued_o       = issued_q;

endmodule

// File: rtl/host_rd_engine.sv
// CCI-P c0 read initiator: bursts line reads from host memory and writes
// each (possibly out-of-order) response into the line buffer slot named by its tag.
module host_rd_engine
  import host_rd_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 16,
  parameter int BUF_AW          = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [41:0]       base_addr_i,
  input  logic [15:0]       num_lines_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              c0_almfull_i,
  output logic              c0_req_valid_o,
  output logic [41:0]       c0_req_addr_o,
  output logic [15:0]       c0_req_mdata_o,
  input  logic              c0_rsp_valid_i,
  input  logic [15:0]       c0_rsp_mdata_i,
  input  logic [511:0]      c0_rsp_data_i,
  output logic              buf_we_o,
  output logic [BUF_AW-1:0] buf_waddr_o,
  output logic [511:0]      buf_wdata_o
);

  localparam logic [CNT_W-1:0] BUF_CAP = CNT_W'(1) << BUF_AW;

  t_rd_state         state_q;
  t_cl_addr          base_q;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  n_d;
  logic              busy_q;
  logic              done_q;
  logic              req_valid_q;
  t_cl_addr          req_addr_q;
  logic [15:0]       req_mdata_q;
  logic              buf_we_q;
  logic [BUF_AW-1:0] buf_waddr_q;
  logic [LINE_W-1:0] buf_wdata_q;

  logic              clear;
  logic              issue;
  logic              rsp_ok;
  logic              can_issue;
  logic              all_received;
  logic [CNT_W-1:0]  issued;
  logic              rsp_mdata_unused;

  assign n_d    = clamp_lines(num_lines_i, BUF_CAP);
  assign clear  = (state_q == IDLE) && start_i;
  assign issue  = (state_q == ISSUE) && !c0_almfull_i && can_issue;
  // Responses outside an active transfer are stale and must not touch the buffer.
  assign rsp_ok = c0_rsp_valid_i && ((state_q == ISSUE) || (state_q == DRAIN));
  assign rsp_mdata_unused = ^c0_rsp_mdata_i;

  rd_tag_tracker #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_tracker (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (clear),
    .issue_i       (issue),
    .rsp_i         (rsp_ok),
    .num_i         (n_q),
    .can_issue_o   (can_issue),
    .all_received_o(all_received),
    .issued_o      (issued)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      n_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_mdata_q <= '0;
      buf_we_q    <= 1'b0;
      buf_waddr_q <= '0;
      buf_wdata_q <= '0;
    end else begin
      req_valid_q <= issue;
      if (issue) begin
        req_addr_q  <= base_q + t_cl_addr'(issued);
        req_mdata_q <= issued[15:0];
      end
      buf_we_q <= rsp_ok;
      if (rsp_ok) begin
        buf_waddr_q <= c0_rsp_mdata_i[BUF_AW-1:0];
        buf_wdata_q <= c0_rsp_data_i;
      end
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            base_q  <= base_addr_i;
            n_q     <= n_d;
            busy_q  <= 1'b1;
            state_q <= (n_d == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (issue && ((issued + CNT_W'(1)) == n_q)) state_q <= DRAIN;
        end
        DRAIN: begin
          if (all_received) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          // Empty transfers arrive here still busy; they spend one cycle pulsing done.
          if (busy_q) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign c0_req_valid_o = req_valid_q;
  assign c0_req_addr_o  = req_addr_q;
  assign c0_req_mdata_o = req_mdata_q;
  assign buf_we_o       = buf_we_q;
  assign buf_waddr_o    = buf_waddr_q;
  assign buf_wdata_o    = buf_wdata_q;

endmodule

// File: tb/tb_host_rd_engine.sv
// Self-checking bench for host_rd_engine: scoreboarded requests and buffer
// writes, a table of whole transfers, and hand sequences for corner cases.
module tb_host_rd_engine;

  localparam int MAXO = 4;
  localparam int AW   = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [41:0]   baseAddr;
  logic [15:0]   numLines;
  logic          busy;
  logic          done;
  logic          almFull;
  logic          reqValid;
  logic [41:0]   reqAddr;
  logic [15:0]   reqMdata;
  logic          rspValid;
  logic [15:0]   rspMdata;
  logic [511:0]  rspData;
  logic          bufWe;
  logic [AW-1:0] bufWaddr;
  logic [511:0]  bufWdata;

  host_rd_engine #(
    .MAX_OUTSTANDING(MAXO),
    .BUF_AW         (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .base_addr_i   (baseAddr),
    .num_lines_i   (numLines),
    .busy_o        (busy),
    .done_o        (done),
    .c0_almfull_i  (almFull),
    .c0_req_valid_o(reqValid),
    .c0_req_addr_o (reqAddr),
    .c0_req_mdata_o(reqMdata),
    .c0_rsp_valid_i(rspValid),
    .c0_rsp_mdata_i(rspMdata),
    .c0_rsp_data_i (rspData),
    .buf_we_o      (bufWe),
    .buf_waddr_o   (bufWaddr),
    .buf_wdata_o   (bufWdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [41:0] addr; logic [15:0] mdata; } reqExp_t;
  typedef struct { logic [AW-1:0] waddr; logic [511:0] data; } bufExp_t;
  typedef struct { logic [41:0] base; logic [15:0] numLines; int expReqs; } vec_t;

  reqExp_t reqExpQ[$];
  bufExp_t bufExpQ[$];
  int      pendQ[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int reqCount, bufCount, doneCount;
  int firstReqCyc, lastReqCyc, doneCyc, lastRspCyc, startCyc;
  int salt = 0;
  reqExp_t monReq;
  bufExp_t monBuf;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic checkData(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] lineData(input int tag, input int s);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = {tag[15:0], 16'(i)} ^ (32'(s) * 32'h9E37_79B1);
    return d;
  endfunction

  // Monitor: compare every request and buffer write against the scoreboard.
  always @(negedge clk) begin
    if (reqValid === 1'b1) begin
      if (reqCount == 0) firstReqCyc = cyc;
      lastReqCyc = cyc;
      reqCount++;
      pendQ.push_back(int'(reqMdata));
      if (reqExpQ.size() == 0) checkOutput("req unexpected", 1, 0);
      else begin
        monReq = reqExpQ.pop_front();
        checkOutput("req addr", reqAddr, monReq.addr);
        checkOutput("req mdata", reqMdata, monReq.mdata);
      end
    end
    if (bufWe === 1'b1) begin
      bufCount++;
      if (bufExpQ.size() == 0) checkOutput("buf_we unexpected", 1, 0);
      else begin
        monBuf = bufExpQ.pop_front();
        checkOutput("buf waddr", bufWaddr, monBuf.waddr);
        checkData("buf wdata", bufWdata, monBuf.data);
      end
    end
    if (done === 1'b1) begin
      doneCount++;
      doneCyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetCounters();
    reqCount = 0; bufCount = 0; doneCount = 0;
    pendQ.delete();
    salt++;
  endtask

  task automatic sendRsp(input int tag, input bit expectWrite);
    bufExp_t b;
    rspValid = 1'b1;
    rspMdata = 16'(tag);
    rspData  = lineData(tag, salt);
    lastRspCyc = cyc;
    if (expectWrite) begin
      b.waddr = AW'(tag);
      b.data  = rspData;
      bufExpQ.push_back(b);
    end
  endtask

  task automatic respondCycle();
    if (pendQ.size() > 0) sendRsp(pendQ.pop_front(), 1'b1);
    else rspValid = 1'b0;
    tick();
  endtask

  task automatic startXfer(input logic [41:0] base, input logic [15:0] num);
    reqExp_t r;
    int lines;
    lines = (num > 16'd1024) ? 1024 : int'(num);
    for (int i = 0; i < lines; i++) begin
      r.addr  = base + 42'(i);
      r.mdata = 16'(i);
      reqExpQ.push_back(r);
    end
    start = 1'b1; baseAddr = base; numLines = num;
    startCyc = cyc;
    tick();
    start = 1'b0;
    checkOutput("busy at t+1", busy, 1);
  endtask

  task automatic runAuto(input int budget, input int doneTarget);
    int c = 0;
    while (doneCount < doneTarget && c < budget) begin
      respondCycle();
      c++;
    end
    rspValid = 1'b0;
    checkOutput("done within budget", doneCount >= doneTarget, 1);
  endtask

  task automatic applyStimulus(input vec_t v);
    resetCounters();
    startXfer(v.base, v.numLines);
    runAuto(6000, 1);
    repeat (3) tick();
    checkOutput("req count", reqCount, v.expReqs);
    checkOutput("buf_we count", bufCount, v.expReqs);
    checkOutput("done pulses", doneCount, 1);
    checkOutput("busy after done", busy, 0);
    checkOutput("req scoreboard drained", reqExpQ.size(), 0);
    if (v.expReqs == 0) checkOutput("done latency empty", doneCyc, startCyc + 2);
    else begin
      checkOutput("done latency", doneCyc, lastRspCyc + 2);
      checkOutput("first req latency", firstReqCyc, startCyc + 2);
    end
    if (v.expReqs > 0 && v.expReqs <= MAXO)
      checkOutput("back-to-back reqs", lastReqCyc, firstReqCyc + v.expReqs - 1);
  endtask

  task automatic checkResetState();
    checkOutput("rst busy", busy, 0);
    checkOutput("rst done", done, 0);
    checkOutput("rst req_valid", reqValid, 0);
    checkOutput("rst req_addr", reqAddr, 0);
    checkOutput("rst req_mdata", reqMdata, 0);
    checkOutput("rst buf_we", bufWe, 0);
    checkOutput("rst buf_waddr", bufWaddr, 0);
    checkOutput("rst buf_wdata", bufWdata == '0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[6];
    int order[8];
    int r0, b0, w;

    vecs[0] = '{base: 42'h1000,          numLines: 16'd4,    expReqs: 4};
    vecs[1] = '{base: 42'h3FF_FFFF_FFFE, numLines: 16'd4,    expReqs: 4};
    vecs[2] = '{base: 42'h500,           numLines: 16'd0,    expReqs: 0};
    vecs[3] = '{base: 42'h20,            numLines: 16'd2000, expReqs: 1024};
    vecs[4] = '{base: 42'hABC,           numLines: 16'd1,    expReqs: 1};
    vecs[5] = '{base: 42'h123,           numLines: 16'd7,    expReqs: 7};
    order   = '{3, 0, 2, 1, 7, 4, 6, 5};

    rst = 1'b1; start = 1'b0; baseAddr = '0; numLines = '0; almFull = 1'b0;
    rspValid = 1'b0; rspMdata = '0; rspData = '0;
    resetCounters();
    tick(); tick();
    checkResetState();
    rst = 1'b0;
    tick();

    $display("[TB] table-driven transfers");
    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    $display("[TB] out-of-order responses");
    resetCounters();
    startXfer(42'h2000, 16'd8);
    for (int i = 0; i < 8; i++) begin
      w = 0;
      while (reqCount <= order[i] && w < 50) begin rspValid = 1'b0; tick(); w++; end
      checkOutput("ooo tag issued", reqCount > order[i], 1);
      sendRsp(order[i], 1'b1);
      tick();
      rspValid = 1'b0;
    end
    w = 0;
    while (doneCount == 0 && w < 20) begin tick(); w++; end
    checkOutput("ooo done", doneCount, 1);
    checkOutput("ooo done latency", doneCyc, lastRspCyc + 2);
    checkOutput("ooo buf writes", bufCount, 8);
    tick();

    $display("[TB] backpressure");
    resetCounters();
    startXfer(42'h4000, 16'd16);
    repeat (20) tick();
    checkOutput("stall at max outstanding", reqCount, MAXO);
    checkOutput("busy while stalled", busy, 1);
    w = 0;
    while (reqCount < 8 && w < 100) begin respondCycle(); w++; end
    almFull = 1'b1;
    r0 = reqCount;
    repeat (10) respondCycle();
    checkOutput("almfull slack", (reqCount - r0) <= 1, 1);
    almFull = 1'b0;
    runAuto(500, 1);
    repeat (2) tick();
    checkOutput("backpressure total reqs", reqCount, 16);
    checkOutput("backpressure done", doneCount, 1);

    $display("[TB] simultaneous issue/response and ignored start");
    resetCounters();
    startXfer(42'h6000, 16'd8);
    repeat (8) tick();
    checkOutput("sim stall", reqCount, MAXO);
    sendRsp(0, 1'b1); tick();
    sendRsp(1, 1'b1); tick();
    rspValid = 1'b0;
    void'(pendQ.pop_front());
    void'(pendQ.pop_front());
    repeat (6) tick();
    checkOutput("sim refill exact", reqCount, 6);
    start = 1'b1; baseAddr = 42'h9999; numLines = 16'd3;
    tick();
    start = 1'b0;
    runAuto(500, 1);
    repeat (3) tick();
    checkOutput("start while busy ignored", reqCount, 8);
    checkOutput("sim done", doneCount, 1);
    b0 = bufCount;
    sendRsp(5, 1'b0); tick();
    rspValid = 1'b0;
    repeat (3) tick();
    checkOutput("idle rsp dropped", bufCount, b0);
    checkOutput("idle buf_we", bufWe, 0);

    $display("[TB] reset mid-transfer");
    resetCounters();
    startXfer(42'h8000, 16'd8);
    w = 0;
    while (reqCount < 3 && w < 50) begin @(negedge clk); #1; w++; end
    rst = 1'b1;
    #1;
    checkOutput("reqs before reset", reqCount, 3);
    reqExpQ.delete();
    pendQ.delete();
    checkResetState();
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin sendRsp(i, 1'b0); tick(); end
    rspValid = 1'b0;
    repeat (3) tick();
    checkOutput("late rsp dropped", bufCount, 0);
    checkResetState();
    applyStimulus('{base: 42'h77, numLines: 16'd5, expReqs: 5});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/host_rd_engine.md
# host_rd_engine

Host-memory read initiator for the CCI-P AFU. On a start command it issues a burst of cache-line read requests on the c0 Tx request channel and collects the (possibly out-of-order) c0 Rx read responses. Each returned line is written into a local line buffer. It is the requester-side counterpart to the AFU's MMIO responder; MMIO-mapped control registers in the AFU top drive `start`/`base_addr`/`num_lines`, and the AFU top packs the request fields into `tx.c0` and unpacks `rx.c0` into the response ports.

## Interface
- `MAX_OUTSTANDING`, default 16: maximum in-flight read requests; range 1..64.
- `BUF_AW`, default 10: line-buffer address width; capacity 2**BUF_AW lines.
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: pulse; begins a transfer when the block is idle.
- `base_addr` in 42: cache-line address of the first line; sampled on an accepted `start`.
- `num_lines` in 16: number of lines to read; sampled on an accepted `start`.
- `busy` out 1: high from an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when all lines have been received.
- `c0_almfull` in 1: `rx.c0TxAlmFull`.
- `c0_req_valid` out 1: read request valid.
- `c0_req_addr` out 42: line address of the request.
- `c0_req_mdata` out 16: request tag, equal to the line index.
- `c0_rsp_valid` in 1: read response valid (rspValid with resp_type = read).
- `c0_rsp_mdata` in 16: tag echoed by the host.
- `c0_rsp_data` in 512: line data.
- `buf_we` out 1: line-buffer write strobe.
- `buf_waddr` out BUF_AW: line-buffer write address.
- `buf_wdata` out 512: line-buffer write data.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- **IDLE**
  - On `start`, latch `base_addr` and `n = min(num_lines, 2**BUF_AW)`, and clear the issued, received and outstanding counters.
  - If n = 0, go to DONE; otherwise go to ISSUE.
  - `start` is ignored in every state other than IDLE.
- **ISSUE**
  - Each cycle where `c0_almfull`=0, outstanding < MAX_OUTSTANDING and issued < n: drive one request with addr = base + issued and mdata = issued, then increment issued.
  - Address addition is 42-bit modulo 2**42; wrap is permitted and not flagged.
  - When issued reaches n, go to DRAIN.
- **DRAIN**: wait until received = n, then go to DONE.
- **DONE**: pulse `done`, drop `busy`, return to IDLE.
- **Responses** (ISSUE or DRAIN)
  - Each `c0_rsp_valid` produces `buf_we` with `buf_waddr = c0_rsp_mdata[BUF_AW-1:0]` and `buf_wdata = c0_rsp_data`.
  - Each response increments received and decrements outstanding.
  - Ordering is irrelevant because the tag selects the slot.
- **Simultaneous issue and response** in one cycle: outstanding is unchanged; both counters update.
- **Responses in IDLE or DONE** (stale, or arriving after a reset): dropped, with no `buf_we` and no counter change.
- **Reset mid-transfer**: all state clears immediately. Requests already in flight are abandoned, and their responses are dropped under the rule above.
- Counter widths: issued and received are 17 bits; outstanding is $clog2(MAX_OUTSTANDING+1) bits and never exceeds MAX_OUTSTANDING.

## Timing
- Reset values: `busy`=0, `done`=0, `c0_req_valid`=0, `c0_req_addr`=0, `c0_req_mdata`=0, `buf_we`=0, `buf_waddr`=0, `buf_wdata`=0; state = IDLE.
- All outputs are registered.
- `start` accepted at cycle t:
  - `busy`=1 at t+1.
  - The first `c0_req_valid` can assert at t+2.
- Request path: `c0_almfull` is sampled in the cycle the request is decided. The request appears on the next edge, so at most one extra request follows an assertion of almfull. This is within the CCI-P almost-full slack.
- Request rate: at most one per cycle; `c0_req_valid` is a single-cycle pulse per request.
- Response path: `c0_rsp_valid` at cycle t gives `buf_we` at t+1, registered.
- Completion:
  - The last response at cycle t gives `done`=1 at t+2 and `busy`=0 at t+2.
  - For n = 0: `start` at t gives `done` at t+2.

## Structure
- Shared package `host_rd_pkg` holds:
  - the state enum `t_rd_state`
  - localparams `LINE_W=512` and `CL_ADDR_W=42`
  - typedef `t_cl_addr`
- The AFU top owns the CCI-P struct packing (`t_ccip_c0_ReqMemHdr`) and the MMIO control registers.
- A natural sub-module is `rd_tag_tracker`, which holds the outstanding/issued/received counters and exposes `can_issue` and `all_received`.
- The line buffer is external to this block.

## Test plan
- **Basic transfer**: base=0x1000, num_lines=4, in-order responses with no almfull → 4 requests with addr 0x1000..0x1003 and mdata 0..3 on consecutive cycles; 4 `buf_we` at addresses 0..3; `done` pulses once, 2 cycles after the 4th response.
- **Out-of-order**: num_lines=8, responses returned in tags 7,0,5,1,6,2,4,3 → `buf_waddr` sequence matches that order; data lands in the correct slots; `done` fires after the 8th response.
- **Backpressure**: MAX_OUTSTANDING=4, num_lines=16, responses withheld → exactly 4 requests, then stall. Separately, hold `c0_almfull`=1 for 10 cycles mid-burst → at most 1 request after assertion, then none until deassertion.
- **Zero length and clamp**: num_lines=0 → no requests, `done` at t+2. num_lines=2000 with BUF_AW=10 → exactly 1024 requests.
- **Simultaneous and ignored**: issue and response in the same cycle → outstanding unchanged. `start` while busy → ignored. A response while IDLE → no `buf_we`.
- **Reset mid-transfer**: assert `rst` after 3 of 8 requests, then return late responses → all outputs at their reset values, no `buf_we`. A new `start` then completes normally.
